// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } pll_sup_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/sync_ff.sv
// Multi-stage bit synchronizer for asynchronous status inputs; resets to 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL RESET, waits for a stable lock, then releases the fast and slow
// downstream resets in order; counts lock losses and lock timeouts.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 50,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int LOCK_STABLE_CYCLES  = 50000,
    parameter int RST_STAGGER         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             clr_cnt,
    output logic             pll_reset,
    output logic             rst_fast_n,
    output logic             rst_slow_n,
    output logic             ready,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);
    localparam int MAX_A   = (PLL_RST_CYCLES > RST_STAGGER) ? PLL_RST_CYCLES : RST_STAGGER;
    localparam int MAX_B   = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ?
                             LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(PLL_RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TO_LAST  = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CYC_W-1:0] STB_LAST = CYC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] STG_LAST = CYC_W'(RST_STAGGER - 1);

    pll_sup_state_t   st;
    logic [CYC_W-1:0] cyc;
    logic             lock_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= PLL_RST;
            pll_reset   <= 1'b1;
            rst_fast_n  <= 1'b0;
            rst_slow_n  <= 1'b0;
            ready       <= 1'b0;
            loss_cnt    <= '0;
            timeout_cnt <= '0;
            cyc         <= '0;
        end else begin
            // RUN has no timed exit, so cyc is frozen there and cannot wrap.
            if (st != RUN) cyc <= cyc + 1'b1;
            case (st)
                PLL_RST: begin
                    if (cyc == RST_LAST) begin
                        st        <= WAIT_LOCK;
                        pll_reset <= 1'b0;
                        cyc       <= '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        st  <= STABILIZE;
                        cyc <= '0;
                    end else if (cyc == TO_LAST) begin
                        st          <= PLL_RST;
                        pll_reset   <= 1'b1;
                        timeout_cnt <= sat_inc(timeout_cnt);
                        cyc         <= '0;
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        st  <= WAIT_LOCK;
                        cyc <= '0;
                    end else if (cyc == STB_LAST) begin
                        st         <= RELEASE;
                        rst_fast_n <= 1'b1;
                        cyc        <= '0;
                    end
                end
                RELEASE, RUN: begin
                    if (!lock_s) begin
                        st         <= PLL_RST;
                        pll_reset  <= 1'b1;
                        rst_fast_n <= 1'b0;
                        rst_slow_n <= 1'b0;
                        ready      <= 1'b0;
                        loss_cnt   <= sat_inc(loss_cnt);
                        cyc        <= '0;
                    end else if (st == RELEASE && cyc == STG_LAST) begin
                        st         <= RUN;
                        rst_slow_n <= 1'b1;
                        ready      <= 1'b1;
                        cyc        <= '0;
                    end
                end
                default: begin
                    st         <= PLL_RST;
                    pll_reset  <= 1'b1;
                    rst_fast_n <= 1'b0;
                    rst_slow_n <= 1'b0;
                    ready      <= 1'b0;
                    cyc        <= '0;
                end
            endcase
            // A clear wins over any increment scheduled above in the same cycle.
            if (clr_cnt) begin
                loss_cnt    <= '0;
                timeout_cnt <= '0;
            end
        end
    end
endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the PLL from the fabric side: synchronizes the asynchronous PLL `lock` flag, drives the PLL `RESET` input, and sequences release of the design's two downstream reset outputs. It sits directly after the PLL instance and runs on the PLL's 50 MHz input reference clock. It keeps running while the PLL output clocks are absent or unstable. It also counts lock losses and lock timeouts, and retries the PLL when lock does not arrive.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of the `pll_lock` synchronizer; legal values are 2 or more.
- `PLL_RST_CYCLES`, 50: number of cycles `pll_reset` is held high per reset attempt (1 µs).
- `LOCK_TIMEOUT_CYCLES`, 500000: maximum cycles spent waiting for lock before the PLL is retried (10 ms).
- `LOCK_STABLE_CYCLES`, 50000: number of consecutive synchronized-lock cycles required before reset release (1 ms).
- `RST_STAGGER`, 16: cycles between deassertion of `rst_fast_n` and deassertion of `rst_slow_n`.

Ports:
- `clk` in 1: 50 MHz reference clock, the same net as the PLL `clkin`.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_lock` in 1: PLL `lock`; asynchronous to `clk`.
- `clr_cnt` in 1: synchronous single-cycle pulse that clears both event counters.
- `pll_reset` out 1: active-high reset to the PLL `RESET` input.
- `rst_fast_n` out 1: active-low reset for the high-speed (clkout0/2) domains. Consumers re-synchronize its deassertion.
- `rst_slow_n` out 1: active-low reset for the 25 MHz (clkout1/3) domains.
- `ready` out 1: high only in the RUN state.
- `state` out 3: current state encoding, for debug.
- `loss_cnt` out 8: number of lock losses seen in RUN; saturates at 255.
- `timeout_cnt` out 8: number of WAIT_LOCK timeouts; saturates at 255.

## Operation
- All outputs are registered. Reset values:
  - state = PLL_RST, with `pll_reset`=1;
  - `rst_fast_n`=0, `rst_slow_n`=0, `ready`=0;
  - both counters 0, synchronizer chain all 0;
  - single shared cycle counter `cyc`=0.
- PLL_RST: `pll_reset`=1. When `cyc`=PLL_RST_CYCLES-1, go to WAIT_LOCK and clear `cyc`.
- WAIT_LOCK: `pll_reset`=0. Each cycle:
  - if synchronized lock (`lock_s`)=1, go to STABILIZE and clear `cyc`;
  - else if `cyc`=LOCK_TIMEOUT_CYCLES-1, increment `timeout_cnt` and go to PLL_RST.
- STABILIZE:
  - if `lock_s`=0, go to WAIT_LOCK and clear `cyc`; the timeout window restarts;
  - if `cyc`=LOCK_STABLE_CYCLES-1 with `lock_s`=1, go to RELEASE, clear `cyc`, and set `rst_fast_n`=1.
- RELEASE:
  - when `cyc`=RST_STAGGER-1, set `rst_slow_n`=1 and `ready`=1, and go to RUN;
  - if `lock_s`=0 at any point here, apply the RUN lock-loss handling below.
- RUN: hold all outputs.
  - If `lock_s`=0, on the next edge drive `rst_fast_n`=0, `rst_slow_n`=0, `ready`=0, increment `loss_cnt`, and go to PLL_RST.
- Both counters saturate at 255.
- `clr_cnt` takes precedence over a same-cycle increment: the counter reads 0 and that event is dropped.
- `cyc` is sized as $clog2 of the largest cycle parameter. It never wraps: every state exit clears it.
- `pll_lock` glitches shorter than one `clk` period may or may not be seen. The design needs only that any loss lasting 2 or more cycles is always caught.

## Timing
- `pll_lock` edge to `lock_s`: SYNC_STAGES to SYNC_STAGES+1 cycles.
- `lock_s` falling in RUN or RELEASE to resets asserted: 1 cycle, so `rst_*_n`=0 exactly one edge after `lock_s`=0.
- Cold start from `rst_n` deassertion to `rst_fast_n`=1, with lock present immediately after PLL reset: PLL_RST_CYCLES + SYNC_STAGES + LOCK_STABLE_CYCLES + ~1 cycles.
- `rst_slow_n` and `ready` rise exactly RST_STAGGER cycles after `rst_fast_n`.
- `rst_n` asserted mid-operation forces every output to its reset value asynchronously. This includes `pll_reset`=1.

## Structure
- Package `pll_sup_pkg` holds:
  - the state enum `pll_sup_state_t` with encodings PLL_RST=0, WAIT_LOCK=1, STABILIZE=2, RELEASE=3, RUN=4;
  - the counter width constant `CNT_W`=8.
- Sub-module `sync_ff`: a parameterized-depth bit synchronizer with async active-low reset to 0. It is reused for any other async status inputs.

## Test plan
Use PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, RST_STAGGER=3.
- Cold start, `pll_lock` rises 2 cycles after `pll_reset` falls → `rst_fast_n` rises 8 cycles after `lock_s`; `rst_slow_n` and `ready` follow 3 cycles later; `loss_cnt`=0.
- `pll_lock` held 0 → `pll_reset` pulses 4 cycles high every 24 cycles; `timeout_cnt` increments 1, 2, 3 per retry.
- `pll_lock` drops for 2 cycles during STABILIZE → state returns to WAIT_LOCK; reset outputs stay 0; no counter changes.
- `pll_lock` drops in RUN → resets and `ready` go to 0 one cycle after `lock_s` falls; `loss_cnt`=1; `pll_reset` goes high.
- 300 forced losses → `loss_cnt` holds 255. `clr_cnt` coincident with a loss → `loss_cnt`=0.
- `rst_n` asserted in RELEASE → all outputs return to their reset values immediately, with no clock edge; operation restarts from PLL_RST.
